// File: rtl/adam_axil_apb_bridge_pkg.sv
// ============================================================================
// Module   : adam_axil_apb_bridge_pkg
// Brief    : Shared FSM states, response codes and decode rule type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package adam_axil_apb_bridge_pkg;

  typedef enum logic [2:0] {
    PAUSED = 3'd0,
    IDLE   = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // end_addr is exclusive
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

endpackage

`default_nettype wire

// File: rtl/adam_axil_apb_bridge_decode.sv
// ============================================================================
// Module   : adam_axil_apb_bridge_decode
// Brief    : Combinational address matcher; first matching rule wins.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adam_axil_apb_bridge_decode
  import adam_axil_apb_bridge_pkg::*;
#(
  parameter int  ADDR_WIDTH = 32,
  parameter int  NO_APBS    = 8,
  parameter type RULE_T     = adam_axil_apb_bridge_pkg::rule_t,
  localparam int IDX_W      = (NO_APBS > 1) ? $clog2(NO_APBS) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  RULE_T [NO_APBS-1:0]   addr_map,
  output logic                  hit,
  output logic [IDX_W-1:0]      idx
);

  // Scan from the top so the lowest matching rule index is the one kept.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NO_APBS - 1; i >= 0; i--) begin
      if ((addr >= addr_map[i].start_addr) && (addr < addr_map[i].end_addr) &&
          (addr_map[i].idx < 32'(NO_APBS))) begin
        hit = 1'b1;
        idx = IDX_W'(addr_map[i].idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adam_axil_apb_bridge_to.sv
// ============================================================================
// Module   : adam_axil_apb_bridge_to
// Brief    : AXI-Lite slave to multi-port APB master bridge with round-robin
//            read/write arbitration, access timeout, decode errors and pause.
// Revision : 1.0
// ============================================================================
`default_nettype none

module adam_axil_apb_bridge_to
  import adam_axil_apb_bridge_pkg::*;
#(
  parameter int  ADDR_WIDTH     = 32,
  parameter int  DATA_WIDTH     = 32,
  parameter int  NO_APBS        = 8,
  parameter int  TIMEOUT_CYCLES = 255,
  parameter type RULE_T         = adam_axil_apb_bridge_pkg::rule_t,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  test,
  input  logic                                  pause_req,
  output logic                                  pause_ack,

  input  logic [ADDR_WIDTH-1:0]                 axil_awaddr,
  input  logic [2:0]                            axil_awprot,
  input  logic                                  axil_awvalid,
  output logic                                  axil_awready,
  input  logic [DATA_WIDTH-1:0]                 axil_wdata,
  input  logic [STRB_WIDTH-1:0]                 axil_wstrb,
  input  logic                                  axil_wvalid,
  output logic                                  axil_wready,
  output logic [1:0]                            axil_bresp,
  output logic                                  axil_bvalid,
  input  logic                                  axil_bready,
  input  logic [ADDR_WIDTH-1:0]                 axil_araddr,
  input  logic [2:0]                            axil_arprot,
  input  logic                                  axil_arvalid,
  output logic                                  axil_arready,
  output logic [DATA_WIDTH-1:0]                 axil_rdata,
  output logic [1:0]                            axil_rresp,
  output logic                                  axil_rvalid,
  input  logic                                  axil_rready,

  output logic [NO_APBS-1:0]                    apb_psel,
  output logic [NO_APBS-1:0]                    apb_penable,
  output logic [NO_APBS-1:0][ADDR_WIDTH-1:0]    apb_paddr,
  output logic [NO_APBS-1:0]                    apb_pwrite,
  output logic [NO_APBS-1:0][DATA_WIDTH-1:0]    apb_pwdata,
  output logic [NO_APBS-1:0][STRB_WIDTH-1:0]    apb_pstrb,
  output logic [NO_APBS-1:0][2:0]               apb_pprot,
  input  logic [NO_APBS-1:0][DATA_WIDTH-1:0]    apb_prdata,
  input  logic [NO_APBS-1:0]                    apb_pready,
  input  logic [NO_APBS-1:0]                    apb_pslverr,

  input  RULE_T [NO_APBS-1:0]                   addr_map
);

  localparam int c_IDX_W = (NO_APBS > 1) ? $clog2(NO_APBS) : 1;
  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
      c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [NO_APBS-1:0] c_SEL_ONE = NO_APBS'(1);

  state_e                  r_state;
  logic [NO_APBS-1:0]      r_psel;
  logic                    r_penable;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic [2:0]              r_pprot;
  logic                    r_pwrite;
  logic                    r_is_write;
  logic                    r_last_write;
  logic                    r_bvalid;
  logic                    r_rvalid;
  logic [1:0]              r_resp;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_pause_ack;
  logic [c_CNT_W-1:0]      r_cnt;

  logic                    w_idle_go;
  logic                    w_grant_wr;
  logic                    w_grant_rd;
  logic [ADDR_WIDTH-1:0]   w_dec_addr;
  logic                    w_hit;
  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_pready;
  logic                    w_pslverr;
  logic [DATA_WIDTH-1:0]   w_prdata;
  logic                    w_timeout;
  logic                    w_unused;

  assign w_unused = test;

  // Pause beats pending requests; on a conflict serve the kind not served last.
  assign w_idle_go  = (r_state == IDLE) && !pause_req;
  assign w_grant_wr = w_idle_go && axil_awvalid && axil_wvalid &&
                      (!axil_arvalid || !r_last_write);
  assign w_grant_rd = w_idle_go && axil_arvalid && !w_grant_wr;
  assign w_dec_addr = w_grant_wr ? axil_awaddr : axil_araddr;

  adam_axil_apb_bridge_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NO_APBS    (NO_APBS),
    .RULE_T     (RULE_T)
  ) u_decode (
    .addr     (w_dec_addr),
    .addr_map (addr_map),
    .hit      (w_hit),
    .idx      (w_idx)
  );

  assign w_pready  = |(apb_pready & r_psel);
  assign w_pslverr = |(apb_pslverr & r_psel);
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NO_APBS; i++) begin
      if (r_psel[i]) w_prdata = w_prdata | apb_prdata[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= PAUSED;
      r_psel       <= '0;
      r_penable    <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_pstrb      <= '0;
      r_pprot      <= '0;
      r_pwrite     <= 1'b0;
      r_is_write   <= 1'b0;
      r_last_write <= 1'b1;
      r_bvalid     <= 1'b0;
      r_rvalid     <= 1'b0;
      r_resp       <= OKAY;
      r_rdata      <= '0;
      r_pause_ack  <= 1'b1;
      r_cnt        <= '0;
    end else begin
      unique case (r_state)
        PAUSED: begin
          if (!pause_req) begin
            r_state     <= IDLE;
            r_pause_ack <= 1'b0;
          end
        end
        IDLE: begin
          if (pause_req) begin
            r_state     <= PAUSED;
            r_pause_ack <= 1'b1;
          end else if (w_grant_wr || w_grant_rd) begin
            r_is_write   <= w_grant_wr;
            r_last_write <= w_grant_wr;
            r_paddr      <= w_dec_addr;
            r_pwrite     <= w_grant_wr;
            r_pwdata     <= w_grant_wr ? axil_wdata : '0;
            r_pstrb      <= w_grant_wr ? axil_wstrb : '0;
            r_pprot      <= w_grant_wr ? axil_awprot : axil_arprot;
            if (w_hit) begin
              r_psel  <= c_SEL_ONE << w_idx;
              r_state <= SETUP;
            end else begin
              r_resp  <= DECERR;
              if (!w_grant_wr) r_rdata <= '0;
              r_state <= RESP;
            end
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_pready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_resp    <= w_pslverr ? SLVERR : OKAY;
            if (!r_is_write) r_rdata <= w_pslverr ? '0 : w_prdata;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_resp    <= SLVERR;
            if (!r_is_write) r_rdata <= '0;
            r_state   <= RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          // Valid rises one cycle after entry and holds until the handshake.
          if (r_is_write) begin
            if (!r_bvalid) begin
              r_bvalid <= 1'b1;
            end else if (axil_bready) begin
              r_bvalid <= 1'b0;
              r_state  <= IDLE;
            end
          end else begin
            if (!r_rvalid) begin
              r_rvalid <= 1'b1;
            end else if (axil_rready) begin
              r_rvalid <= 1'b0;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= PAUSED;
      endcase
    end
  end

  assign pause_ack    = r_pause_ack;
  assign axil_awready = w_grant_wr;
  assign axil_wready  = w_grant_wr;
  assign axil_arready = w_grant_rd;
  assign axil_bvalid  = r_bvalid;
  assign axil_bresp   = r_resp;
  assign axil_rvalid  = r_rvalid;
  assign axil_rresp   = r_resp;
  assign axil_rdata   = r_rdata;

  for (genvar g = 0; g < NO_APBS; g++) begin : g_apb
    assign apb_psel[g]    = r_psel[g];
    assign apb_penable[g] = r_penable & r_psel[g];
    assign apb_paddr[g]   = r_paddr;
    assign apb_pwrite[g]  = r_pwrite;
    assign apb_pwdata[g]  = r_pwdata;
    assign apb_pstrb[g]   = r_pstrb;
    assign apb_pprot[g]   = r_pprot;
  end

endmodule

`default_nettype wire

// File: tb/tb_adam_axil_apb_bridge_to.sv
// ============================================================================
// Module   : tb_adam_axil_apb_bridge_to
// Brief    : Directed self-checking bench for the AXI-Lite to APB bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adam_axil_apb_bridge_to;
  import adam_axil_apb_bridge_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 8;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst, test, pause_req, pause_ack;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [N-1:0]          apb_psel, apb_penable, apb_pwrite, apb_pready, apb_pslverr;
  logic [N-1:0][AW-1:0]  apb_paddr;
  logic [N-1:0][DW-1:0]  apb_pwdata, apb_prdata;
  logic [N-1:0][3:0]     apb_pstrb;
  logic [N-1:0][2:0]     apb_pprot;
  rule_t [N-1:0]         addr_map;

  always #5 clk = ~clk;

  adam_axil_apb_bridge_to #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_APBS(N), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .test(test), .pause_req(pause_req), .pause_ack(pause_ack),
    .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid), .axil_awready(awready),
    .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
    .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
    .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid), .axil_arready(arready),
    .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_paddr(apb_paddr),
    .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
    .apb_pprot(apb_pprot), .apb_prdata(apb_prdata), .apb_pready(apb_pready),
    .apb_pslverr(apb_pslverr), .addr_map(addr_map)
  );

  // APB slave model: pready after slv_wait low ACCESS cycles, prdata = port index
  int slv_wait = 1;
  logic slv_err = 1'b0;
  int acc_cnt = 0;
  always @(posedge clk) acc_cnt <= ((|apb_penable) && !(|apb_pready)) ? acc_cnt + 1 : 0;
  always_comb begin
    for (int j = 0; j < N; j++) begin
      apb_pready[j]  = apb_psel[j] & apb_penable[j] & (acc_cnt >= slv_wait);
      apb_prdata[j]  = 32'(j);
      apb_pslverr[j] = slv_err;
    end
  end

  // Protocol monitor
  int psel_cnt [N];
  int pen_cycles = 0, multi_err = 0, seq_err = 0;
  logic prev_setup = 1'b0, prev_access = 1'b0;
  logic [AW-1:0] last_paddr = '0;
  logic [DW-1:0] last_pwdata = '0;
  logic [3:0]    last_pstrb = '0;
  initial for (int j = 0; j < N; j++) psel_cnt[j] = 0;
  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < N; j++) begin
        if (apb_psel[j]) psel_cnt[j]++;
        if (apb_psel[j] && !apb_penable[j]) begin
          last_paddr = apb_paddr[j]; last_pwdata = apb_pwdata[j]; last_pstrb = apb_pstrb[j];
        end
      end
      if (|apb_penable) pen_cycles++;
      if ($countones(apb_psel) > 1) multi_err++;
      if ((apb_penable & ~apb_psel) != '0) seq_err++;
      if (prev_setup && !(|(apb_psel & apb_penable))) seq_err++;
      if ((|apb_penable) && !(prev_setup || prev_access)) seq_err++;
      prev_setup  = |(apb_psel & ~apb_penable);
      prev_access = |(apb_psel & apb_penable);
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output int lat);
    int n;
    logic to;
    awaddr = a; awprot = 3'd0; wdata = d; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1; n = 0;
    while (!(awready && wready) && n < 100) begin @(posedge clk); #1; n++; end
    to = (n >= 100);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; lat = 0;
    while (!bvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    to = to | !bvalid;
    resp = bresp;
    @(posedge clk); #1; bready = 1'b0;
    chk("wr_handshake_bound", 32'(to), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int n;
    logic to;
    araddr = a; arprot = 3'd0; arvalid = 1'b1; rready = 1'b0;
    #1; n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    to = (n >= 100);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1; lat = 0;
    while (!rvalid && lat < 100) begin @(posedge clk); #1; lat++; end
    to = to | !rvalid;
    d = rdata; resp = rresp;
    @(posedge clk); #1; rready = 1'b0;
    chk("rd_handshake_bound", 32'(to), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int lat, n, served, ps0, pen0, tot0, tot1;
    int order [4];
    logic rd_acc, wr_acc, r_hs, b_hs, rdy_seen, to;

    for (int j = 0; j < N; j++) begin
      addr_map[j].idx        = 32'(j);
      addr_map[j].start_addr = 32'(j) << 16;
      addr_map[j].end_addr   = 32'(j + 1) << 16;
    end
    rst = 1'b1; test = 1'b0; pause_req = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = 32'h0001_0000; arprot = '0; arvalid = 1'b1; rready = 1'b0;

    // Reset state while paused with a pending AR
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_pause_ack", 32'(pause_ack), 32'd1);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_psel", 32'(apb_psel), 32'd0);
    chk("rst_valids", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_paddr", apb_paddr[0], 32'd0);
    arvalid = 1'b0; pause_req = 1'b0;
    @(posedge clk); #1;
    chk("unpause_ack", 32'(pause_ack), 32'd0);

    // Write then read each port
    slv_wait = 1; slv_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      ps0 = psel_cnt[i]; tot0 = 0;
      for (int j = 0; j < N; j++) tot0 += psel_cnt[j];
      axi_write(32'(i) << 16, 32'hA5A5_0000 | 32'(i), resp, lat);
      chk($sformatf("bresp_p%0d", i), 32'(resp), 32'd0);
      chk($sformatf("wr_lat_p%0d", i), 32'(lat), 32'd4);
      chk($sformatf("paddr_p%0d", i), last_paddr, 32'(i) << 16);
      chk($sformatf("pwdata_p%0d", i), last_pwdata, 32'hA5A5_0000 | 32'(i));
      axi_read(32'(i) << 16, d, resp, lat);
      chk($sformatf("rdata_p%0d", i), d, 32'(i));
      chk($sformatf("rresp_p%0d", i), 32'(resp), 32'd0);
      chk($sformatf("rd_pstrb_p%0d", i), 32'(last_pstrb), 32'd0);
      tot1 = 0;
      for (int j = 0; j < N; j++) tot1 += psel_cnt[j];
      chk($sformatf("psel_own_p%0d", i), 32'(psel_cnt[i] - ps0), 32'd6);
      chk($sformatf("psel_all_p%0d", i), 32'(tot1 - tot0), 32'd6);
    end

    // Timeout with pready held low, then pready on the last allowed cycle
    slv_wait = 100; pen0 = pen_cycles;
    axi_read(32'h0002_0000, d, resp, lat);
    chk("to_pen_cycles", 32'(pen_cycles - pen0), 32'd4);
    chk("to_rresp", 32'(resp), 32'd2);
    chk("to_rdata", d, 32'd0);
    slv_wait = 3; pen0 = pen_cycles;
    axi_read(32'h0002_0000, d, resp, lat);
    chk("edge_pen_cycles", 32'(pen_cycles - pen0), 32'd4);
    chk("edge_rresp", 32'(resp), 32'd0);
    chk("edge_rdata", d, 32'd2);

    // Decode miss
    slv_wait = 1; tot0 = 0;
    for (int j = 0; j < N; j++) tot0 += psel_cnt[j];
    axi_read(32'h0009_0000, d, resp, lat);
    chk("dec_rresp", 32'(resp), 32'd3);
    chk("dec_rdata", d, 32'd0);
    chk("dec_rd_lat", 32'(lat), 32'd1);
    axi_write(32'h0009_0000, 32'h1234_5678, resp, lat);
    chk("dec_bresp", 32'(resp), 32'd3);
    tot1 = 0;
    for (int j = 0; j < N; j++) tot1 += psel_cnt[j];
    chk("dec_no_psel", 32'(tot1 - tot0), 32'd0);

    // Slave error on a write, clean read afterwards
    slv_err = 1'b1;
    axi_write(32'h0003_0000, 32'hDEAD_BEEF, resp, lat);
    chk("slverr_bresp", 32'(resp), 32'd2);
    slv_err = 1'b0;
    axi_read(32'h0003_0000, d, resp, lat);
    chk("after_err_rresp", 32'(resp), 32'd0);
    chk("after_err_rdata", d, 32'd3);

    // Arbitration: last served is a write, so the read goes first
    axi_write(32'h0000_0000, 32'h0, resp, lat);
    araddr = 32'h0001_0000; awaddr = 32'h0004_0000; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    served = 0; n = 0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    #1;
    while (served < 4 && n < 300) begin
      rd_acc = arvalid && arready;
      wr_acc = awvalid && wvalid && awready && wready;
      r_hs = rvalid && rready;
      b_hs = bvalid && bready;
      @(posedge clk); #1; n++;
      if (rd_acc) begin order[served] = 0; served++; arvalid = 1'b0; end
      if (wr_acc) begin order[served] = 1; served++; awvalid = 1'b0; wvalid = 1'b0; end
      if (r_hs) arvalid = 1'b1;
      if (b_hs) begin awvalid = 1'b1; wvalid = 1'b1; end
      #1;
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("arb_served", 32'(served), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("arb_order_%0d", k), 32'(order[k]), 32'(k % 2));
    chk("arb_drained", 32'({bvalid, rvalid}), 32'd0);
    bready = 1'b0; rready = 1'b0;

    // Pause raised during ACCESS of a write, with an AR queued behind it
    slv_wait = 3;
    awaddr = 32'h0005_0000; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1; n = 0;
    while (!(awready && wready) && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    while (!(|apb_penable) && n < 200) begin @(posedge clk); #1; n++; end
    pause_req = 1'b1; araddr = 32'h0006_0000; arvalid = 1'b1; bready = 1'b1;
    while (!bvalid && n < 300) begin @(posedge clk); #1; n++; end
    to = (n >= 300);
    chk("pause_bound", 32'(to), 32'd0);
    chk("pause_bvalid", 32'(bvalid), 32'd1);
    chk("pause_ack_busy", 32'(pause_ack), 32'd0);
    chk("pause_bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1; bready = 1'b0;
    rdy_seen = arready | awready | wready;
    repeat (5) begin
      @(posedge clk); #1;
      rdy_seen = rdy_seen | arready | awready | wready;
    end
    chk("paused_ack", 32'(pause_ack), 32'd1);
    chk("paused_no_ready", 32'(rdy_seen), 32'd0);
    pause_req = 1'b0;
    axi_read(32'h0006_0000, d, resp, lat);
    chk("resume_rdata", d, 32'd6);
    chk("resume_rresp", 32'(resp), 32'd0);

    // Reset in the middle of an ACCESS abandons the transfer
    slv_wait = 100;
    araddr = 32'h0001_0000; arvalid = 1'b1;
    #1; n = 0;
    while (!arready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1; arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_psel", 32'(apb_psel), 32'd0);
    chk("midrst_ack", 32'(pause_ack), 32'd1);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_rvalid", 32'(rvalid), 32'd0);
    rready = 1'b0;

    chk("multi_psel", 32'(multi_err), 32'd0);
    chk("setup_access_seq", 32'(seq_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adam_axil_apb_bridge_to.md
Name: adam_axil_apb_bridge_to

Overview:
- AXI-Lite slave to NO_APBS-way APB master bridge, next generation of the peripheral-bus bridge.
- Adds fair read/write arbitration, per-access APB timeout, decode-error responses and pause support with a defined drain rule.
- One APB transfer in flight at a time.
- Sits between the system AXI-Lite crossbar and the peripheral APB segment.

Parameters:
- ADDR_WIDTH, 32, address width of AXI-Lite and APB.
- DATA_WIDTH, 32, data width; STRB_WIDTH = DATA_WIDTH/8.
- NO_APBS, 8, number of APB slave ports (>=1).
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles before forced error; 0 disables the timeout.
- rule_t, type, address rule {idx, start_addr, end_addr}, end exclusive.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- test  in  1  test mode; no functional effect in this block.
- pause_req  in  1  request to quiesce.
- pause_ack  out  1  bridge idle and paused.
- axil  slave  AXI_LITE(ADDR_WIDTH, DATA_WIDTH)  upstream port.
- apb  master  APB(ADDR_WIDTH, DATA_WIDTH)[NO_APBS]  downstream ports.
- addr_map  in  rule_t[NO_APBS]  decode table, quasi-static.

Behaviour:
- Reset values:
  - All APB psel and penable = 0; paddr, pwdata, pstrb, pprot and pwrite = 0.
  - awready, wready, arready, bvalid and rvalid = 0; bresp and rresp = 0; rdata = 0.
  - pause_ack = 1; state = PAUSED.
- FSM states:
  - PAUSED: pause_ack = 1, no readies. Go to IDLE on the first cycle pause_req = 0.
  - IDLE:
    - If pause_req = 1, go to PAUSED; pause wins over pending requests.
    - Otherwise arbitrate between write (awvalid & wvalid) and read (arvalid).
    - Round-robin arbitration: on conflict, serve the opposite of the last served kind; after reset, reads have priority.
    - Winner is accepted in this cycle: awready+wready together, or arready, each for exactly 1 cycle.
    - Address, data, strobe and prot are latched.
    - Decode result is registered: first matching rule, lowest index wins.
  - Decode miss: go to RESP with resp = 2'b11 (DECERR); no APB activity.
  - SETUP: the selected psel = 1, penable = 0, plus paddr, pwrite, pwdata, pprot and pstrb. pstrb = 0 for reads. Lasts 1 cycle, then ACCESS.
  - ACCESS: penable = 1.
    - On pready: latch prdata and pslverr (resp = pslverr ? 2'b10 : 2'b00), drop psel/penable next cycle, go to RESP.
    - If TIMEOUT_CYCLES != 0 and pready has been low for TIMEOUT_CYCLES consecutive ACCESS cycles: abort, drop psel/penable, resp = 2'b10, rdata = 0, go to RESP.
  - RESP:
    - Write: drive bvalid = 1. Read: drive rvalid = 1 with rdata (0 on error).
    - Hold until bready or rready; then go to IDLE.
    - bresp, rresp and rdata stay stable while valid.
- Timing:
  - Minimum latency is 3 cycles from the accept edge to the valid rising: SETUP, ACCESS and RESP-register.
  - Back-to-back transactions: one IDLE cycle between transactions.
- Only one psel is asserted at any time; the others stay 0 throughout.
- Pause:
  - pause_req is sampled only in IDLE, so an in-flight transfer always completes, including its response handshake, before pause_ack rises.
  - Behaviour when pause_req drops while in PAUSED is defined under PAUSED.
- Reset mid-operation: immediate return to PAUSED; any APB transfer is abandoned and no AXI response is issued.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1); it saturates and clears on entering ACCESS.
  - pready arriving on the timeout cycle itself counts as success: pready wins.
- AW without W (or W without AW) is not accepted; the bridge waits for both.

Decomposition:
- adam_axil_apb_bridge_pkg holds:
  - state enum (PAUSED, IDLE, SETUP, ACCESS, RESP);
  - resp constants OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11.
- Sub-module adam_axil_apb_bridge_decode: combinational rule matcher with inputs addr and addr_map; outputs hit and idx.

Test Plan:
- Write then read to each port i (address i<<16), slave pready after 1 wait cycle, prdata = i:
  - bresp = 00;
  - rdata = i, rresp = 00;
  - psel only on apb[i];
  - SETUP precedes ACCESS by exactly 1 cycle.
- Read to 0x0009_0000 (no rule matches, NO_APBS = 8): rresp = 11 with no psel on any port; write to same address gives bresp = 11.
- TIMEOUT_CYCLES = 4, pready held 0:
  - penable high for exactly 4 cycles, then dropped;
  - rresp = 10, rdata = 0.
  - Repeat with pready on the 4th cycle: rresp = 00.
- Slave asserts pslverr = 1 on a write: bresp = 10; next read to same slave with pslverr = 0 returns 00.
- AW+W and AR valid simultaneously, 4 times: served order read, write, read, write; no starvation.
- pause_req raised during ACCESS:
  - transfer completes and bvalid handshake occurs;
  - then pause_ack = 1 and no readies while pause_req = 1;
  - after pause_req = 0 the pending AR is accepted.
